// File: rtl/fft_mul_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : fft_mul_share_arb
// Purpose  : Shares one external pipelined signed multiplier among NREQ
//            requesters (e.g. twiddle multipliers of several butterfly
//            lanes). A round-robin arbiter picks one requester per cycle,
//            drives the multiplier operands and clock-enable, and a tag
//            pipeline running alongside the multiplier returns each product
//            with the index of its originator. Consumer backpressure or a
//            low global enable freezes everything, multiplier included.
// Ports    : clk, reset (async, active-high), ce (global enable)
//            req_valid/req_ready/req_a/req_b : requester side (packed)
//            mul_din0/mul_din1/mul_ce/mul_dout : external multiplier
//            rsp_valid/rsp_id/rsp_p/rsp_ready : product consumer side
//            busy : at least one tag in flight
// Revision : 1.0 - initial release
// ============================================================================
module fft_mul_share_arb #(
  parameter int NREQ    = 4,
  parameter int A_W     = 20,
  parameter int B_W     = 15,
  parameter int P_W     = 35,
  parameter int MUL_LAT = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*A_W-1:0]       req_a,
  input  logic [NREQ*B_W-1:0]       req_b,
  output logic [A_W-1:0]            mul_din0,
  output logic [B_W-1:0]            mul_din1,
  output logic                      mul_ce,
  input  logic [P_W-1:0]            mul_dout,
  output logic                      rsp_valid,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [P_W-1:0]            rsp_p,
  input  logic                      rsp_ready,
  output logic                      busy
);

  localparam int ID_W = $clog2(NREQ);

  logic [ID_W-1:0] r_last_gnt;
  logic [MUL_LAT-1:0] r_vld;
  logic [ID_W-1:0] r_id [MUL_LAT];

  logic            w_adv;
  logic            w_any;
  logic            w_xfer;
  logic [NREQ-1:0] w_gnt;
  logic [ID_W-1:0] w_gnt_idx;

  // Reset is folded into the advance term so that no handshake can be
  // signalled while the block is held in reset.
  assign w_adv  = ce & ~reset & (~rsp_valid | rsp_ready);
  assign mul_ce = w_adv;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_any     = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(r_last_gnt) + k) % NREQ;
      if (!w_any && req_valid[idx]) begin
        w_any      = 1'b1;
        w_gnt[idx] = 1'b1;
        w_gnt_idx  = ID_W'(idx);
      end
    end
  end

  assign req_ready = w_gnt & {NREQ{w_adv}};
  assign w_xfer    = w_any & w_adv;

  // Operands of the winner, or zero when nobody is requesting.
  always_comb begin
    mul_din0 = '0;
    mul_din1 = '0;
    if (w_any) begin
      mul_din0 = req_a[int'(w_gnt_idx)*A_W +: A_W];
      mul_din1 = req_b[int'(w_gnt_idx)*B_W +: B_W];
    end
  end

  // Pointer moves only on an actual transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_gnt <= ID_W'(NREQ-1);
    end else if (w_xfer) begin
      r_last_gnt <= w_gnt_idx;
    end
  end

  // Tag pipeline: advances in lock-step with the multiplier (same enable),
  // so the tag at the last stage always belongs to the product on mul_dout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
      for (int s = 0; s < MUL_LAT; s++) begin
        r_id[s] <= '0;
      end
    end else if (w_adv) begin
      r_vld[0] <= w_xfer;
      r_id[0]  <= w_gnt_idx;
      for (int s = 1; s < MUL_LAT; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_id[s]  <= r_id[s-1];
      end
    end
  end

  assign rsp_valid = r_vld[MUL_LAT-1];
  assign rsp_id    = r_id[MUL_LAT-1];
  assign rsp_p     = mul_dout;
  assign busy      = |r_vld;

endmodule
`default_nettype wire

// File: tb/tb_fft_mul_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_mul_share_arb
// Purpose  : Self-checking bench for fft_mul_share_arb. Provides a behavioural
//            pipelined multiplier, directed scenarios and randomized traffic,
//            all checked against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_mul_share_arb;

  localparam int NREQ    = 4;
  localparam int A_W     = 20;
  localparam int B_W     = 15;
  localparam int P_W     = 35;
  localparam int MUL_LAT = 2;
  localparam int ID_W    = $clog2(NREQ);

  logic                    clk;
  logic                    reset;
  logic                    ce;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*A_W-1:0]     req_a;
  logic [NREQ*B_W-1:0]     req_b;
  logic [A_W-1:0]          mul_din0;
  logic [B_W-1:0]          mul_din1;
  logic                    mul_ce;
  logic [P_W-1:0]          mul_dout;
  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [P_W-1:0]          rsp_p;
  logic                    rsp_ready;
  logic                    busy;

  fft_mul_share_arb #(
    .NREQ(NREQ), .A_W(A_W), .B_W(B_W), .P_W(P_W), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_ce(mul_ce),
    .mul_dout(mul_dout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural external multiplier: MUL_LAT enabled stages, not reset.
  logic signed [P_W-1:0] mpipe [MUL_LAT];
  always_ff @(posedge clk) begin
    if (mul_ce) begin
      mpipe[0] <= $signed(mul_din0) * $signed(mul_din1);
      for (int s = 1; s < MUL_LAT; s++) mpipe[s] <= mpipe[s-1];
    end
  end
  assign mul_dout = mpipe[MUL_LAT-1];

  // Requester stimulus: held until accepted.
  logic                  pend_v [NREQ];
  logic signed [A_W-1:0] pend_a [NREQ];
  logic signed [B_W-1:0] pend_b [NREQ];

  always_comb begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = pend_v[i];
      req_a[i*A_W +: A_W]   = pend_a[i];
      req_b[i*B_W +: B_W]   = pend_b[i];
    end
  end

  // Reference model: queue of products in flight, each with the number of
  // enabled cycles elapsed since its transfer.
  typedef struct {
    int     id;
    longint p;
    int     age;
  } ent_t;
  ent_t q[$];
  int   ptr;
  int   acc_idx;

  int n_cmp;
  int n_err;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at posedge+1 with inputs for this cycle set; returns at the next
  // posedge+1 with the accepted request (if any) retired.
  task automatic step();
    bit     exp_vld;
    bit     adv;
    int     w;
    longint exp_rdy;
    #1;
    if (reset) begin
      q.delete();
      ptr = NREQ - 1;
    end
    exp_vld = (q.size() > 0) && (q[0].age == MUL_LAT);
    adv     = ce && !reset && (!exp_vld || rsp_ready);
    w = -1;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (ptr + k) % NREQ;
      if (w < 0 && pend_v[idx]) w = idx;
    end
    exp_rdy = (adv && w >= 0) ? (longint'(1) << w) : 0;

    chk("mul_ce", mul_ce, adv);
    chk("req_ready", req_ready, exp_rdy);
    chk("rsp_valid", rsp_valid, exp_vld);
    chk("busy", busy, q.size() > 0);
    if (exp_vld) begin
      chk("rsp_id", rsp_id, q[0].id);
      chk("rsp_p", $signed(rsp_p), q[0].p);
    end
    chk("mul_din0", $signed(mul_din0), (w >= 0) ? longint'(pend_a[w]) : 0);
    chk("mul_din1", $signed(mul_din1), (w >= 0) ? longint'(pend_b[w]) : 0);

    acc_idx = -1;
    if (adv) begin
      if (exp_vld) void'(q.pop_front());
      foreach (q[k]) q[k].age++;
      if (w >= 0) begin
        ent_t e;
        e.id  = w;
        e.p   = longint'(pend_a[w]) * longint'(pend_b[w]);
        e.age = 1;
        q.push_back(e);
        ptr     = w;
        acc_idx = w;
      end
    end
    @(posedge clk);
    #1;
    if (acc_idx >= 0) pend_v[acc_idx] = 1'b0;
  endtask

  task automatic set_req(input int i, input longint a, input longint b);
    pend_v[i] = 1'b1;
    pend_a[i] = A_W'(a);
    pend_b[i] = B_W'(b);
  endtask

  task automatic idle(input int n);
    ce = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    ptr = NREQ - 1;
    acc_idx = -1;
    for (int i = 0; i < NREQ; i++) begin
      pend_v[i] = 1'b0;
      pend_a[i] = '0;
      pend_b[i] = '0;
    end
    reset = 1'b1;
    ce = 1'b1;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    step();
    reset = 1'b0;

    // Single request: requester 2, 3 * -5
    set_req(2, 3, -5);
    step();
    step();
    chk("single_valid", rsp_valid, 1);
    chk("single_id", rsp_id, 2);
    chk("single_p", $signed(rsp_p), -15);
    idle(3);

    // All requesters continuously valid
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend_v[i]) set_req(i, longint'($urandom), longint'($urandom));
      step();
    end
    for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
    idle(4);

    // Backpressure: requester 0 streams a=1..4, b=2; rsp_ready low cycles 3..5
    begin
      int nxt;
      nxt = 1;
      for (int c = 0; c < 12; c++) begin
        if (!pend_v[0] && nxt <= 4) begin
          set_req(0, nxt, 2);
          nxt++;
        end
        rsp_ready = !(c >= 3 && c <= 5);
        if (c == 4) begin
          chk("bp_held_valid", rsp_valid, 1);
          chk("bp_held_p", $signed(rsp_p), 4);
          chk("bp_held_id", rsp_id, 0);
        end
        step();
      end
    end
    idle(3);

    // ce toggling with extreme operands
    set_req(1, -524288, -16384);
    for (int c = 0; c < 6; c++) begin
      ce = (c % 2 == 0);
      if (c == 4) begin
        chk("ce_valid", rsp_valid, 1);
        chk("ce_p", $signed(rsp_p), 64'sd8589934592);
      end
      step();
    end
    idle(3);

    // Reset with two tags in flight
    set_req(1, 7, 9);
    step();
    set_req(2, -11, 13);
    step();
    set_req(0, 5, 5);
    set_req(3, 6, 6);
    reset = 1'b1;
    #1;
    chk("midrst_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    #1;
    step();
    reset = 1'b0;
    chk("postrst_valid", rsp_valid, 0);
    step();
    idle(5);

    // Fairness: grant 1 alone, then 1 and 3 contend
    set_req(1, 2, 3);
    step();
    set_req(1, 4, 5);
    set_req(3, 6, 7);
    #1;
    chk("fair_first", req_ready, 4'b1000);
    #1;
    step();
    #1;
    chk("fair_second", req_ready, 4'b0010);
    #1;
    step();
    idle(4);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend_v[i] && $urandom_range(0, 99) < 40)
          set_req(i, longint'($urandom), longint'($urandom));
      ce = ($urandom_range(0, 99) < 85);
      rsp_ready = ($urandom_range(0, 99) < 70);
      step();
    end
    for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
